pulse_capture: RTL and testbench

Parametrised capture and framing stage for pulse-simulator sample streams. It takes the shared signed sample bus and per-channel enable strobes produced by `pulse_sim`-style sources (truth, readout, ...), and keeps a hold register per channel. Once every channel has been refreshed, it assembles one frame and buffers it in a FIFO with a ready/valid output. It sits between the simulator core and any downstream consumer or host readout path.

---
 rtl/pulse_pkg.sv | 10 +
 rtl/pulse_fifo.sv | 52 +++++
 rtl/pulse_capture.sv | 106 ++++++++++
 tb/tb_pulse_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared constants for the pulse simulator capture path.
package pulse_pkg;

    localparam int PULSE_DW   = 23;
    localparam int PULSE_NCH  = 2;
    localparam int CH_TRUTH   = 0;
    localparam int CH_READOUT = 1;
    localparam int PULSE_TS_W = 32;

endpackage

// File: rtl/pulse_fifo.sv
// Synchronous frame FIFO with wrap-bit pointers and an asynchronous active-low reset.
module pulse_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/pulse_capture.sv
// Per-channel hold registers, frame assembly and output FIFO for pulse sample streams.
// Optional frame timestamping is enabled with PULSE_CAPTURE_TS_EN.
module pulse_capture
    import pulse_pkg::*;
#(
    parameter int NCH   = PULSE_NCH,
    parameter int DW    = PULSE_DW,
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_en,
    input  logic [DW-1:0]     in_data,
    output logic [NCH*DW-1:0] hold,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [NCH*DW-1:0] o_data,
    output logic              overrun,
    output logic [15:0]       drops
`ifdef PULSE_CAPTURE_TS_EN
    ,
    output logic [PULSE_TS_W-1:0] o_ts
`endif
);

    localparam int FW = NCH * DW;
`ifdef PULSE_CAPTURE_TS_EN
    localparam int EW = FW + PULSE_TS_W;
`else
    localparam int EW = FW;
`endif

    logic [FW-1:0]  hold_next;
    logic [NCH-1:0] pend;
    logic           complete;
    logic           pop;
    logic           full;
    logic           empty;
    logic [EW-1:0]  wdata;
    logic [EW-1:0]  rdata;

    always_comb begin
        hold_next = hold;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (in_en[i]) begin
                hold_next[i*DW +: DW] = in_data;
            end
        end
    end

    assign complete = &(pend | in_en);
    assign o_valid  = !empty;
    assign pop      = o_valid && o_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold    <= '0;
            pend    <= '0;
            overrun <= 1'b0;
            drops   <= '0;
        end else begin
            hold <= hold_next;
            pend <= complete ? '0 : (pend | in_en);
            if (|(pend & in_en)) begin
                overrun <= 1'b1;
            end
            if (complete && full && !pop && (drops != '1)) begin
                drops <= drops + 16'd1;
            end
        end
    end

`ifdef PULSE_CAPTURE_TS_EN
    logic [PULSE_TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end

    assign wdata  = {ts_cnt, hold_next};
    assign o_data = rdata[FW-1:0];
    assign o_ts   = rdata[EW-1:FW];
`else
    assign wdata  = hold_next;
    assign o_data = rdata;
`endif

    pulse_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (complete),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_pulse_capture.sv
// Scoreboard bench for pulse_capture: directed strobes push expected frames, a monitor pops and compares.
module tb_pulse_capture;
    import pulse_pkg::*;

    localparam int NCH   = 2;
    localparam int DW    = 23;
    localparam int DEPTH = 16;
    localparam int FW    = NCH * DW;

    logic           clk     = 1'b0;
    logic           rst     = 1'b1;
    logic [NCH-1:0] in_en   = '0;
    logic [DW-1:0]  in_data = '0;
    logic           o_ready = 1'b0;
    logic [FW-1:0]  hold;
    logic           o_valid;
    logic [FW-1:0]  o_data;
    logic           overrun;
    logic [15:0]    drops;
`ifdef PULSE_CAPTURE_TS_EN
    logic [31:0]    o_ts;
`endif

    pulse_capture #(
        .NCH   (NCH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_en   (in_en),
        .in_data (in_data),
        .hold    (hold),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .overrun (overrun),
        .drops   (drops)
`ifdef PULSE_CAPTURE_TS_EN
        ,
        .o_ts    (o_ts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] data;
        logic [31:0]   ts;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          passed = 0;
    int unsigned cyc    = 0;

    // Edges seen since reset release; equals the DUT timestamp at a completion edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic logic [FW-1:0] mk(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
        return {c1, c0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_frame(input logic [FW-1:0] d);
        exp_t e;
        e.data = d;
        e.ts   = cyc;
        q.push_back(e);
    endtask

    task automatic drive(input logic [NCH-1:0] en, input logic [DW-1:0] d);
        in_en   = en;
        in_data = d;
        @(posedge clk);
        #1;
        in_en = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(q.size()), 64'd0);
        check("valid_after_drain", 64'(o_valid), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && o_valid && o_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: got %0h expected none", o_data);
                end else begin
                    e = q.pop_front();
                    check("frame", 64'(o_data), 64'(e.data));
`ifdef PULSE_CAPTURE_TS_EN
                    check("frame_ts", 64'(o_ts), 64'(e.ts));
`endif
                end
            end
        end
    end

    initial begin : stim
        #2 rst = 1'b0;
        #8;
        check("rst_hold", 64'(hold), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_drops", 64'(drops), 64'd0);
        #12 rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-strobe frame
        o_ready = 1'b1;
        drive(2'b01, 23'd100);
        check("basic_hold0", 64'(hold), 64'(mk(23'd100, 23'd0)));
        check("basic_no_valid", 64'(o_valid), 64'd0);
        expect_frame(mk(23'd100, 23'(-5)));
        drive(2'b10, 23'(-5));
        check("basic_valid", 64'(o_valid), 64'd1);
        check("basic_overrun", 64'(overrun), 64'd0);
        drain();

        // Both channels together, then re-strobe of ch0
        expect_frame(mk(23'd7, 23'd7));
        drive(2'b11, 23'd7);
        check("both_valid", 64'(o_valid), 64'd1);
        drive(2'b01, 23'd1);
        check("restrobe_ovr0", 64'(overrun), 64'd0);
        drive(2'b01, 23'd2);
        check("restrobe_ovr1", 64'(overrun), 64'd1);
        expect_frame(mk(23'd2, 23'd3));
        drive(2'b10, 23'd3);
        drain();
        check("restrobe_sticky", 64'(overrun), 64'd1);

        // Backpressure: 18 frames into 16 slots
        o_ready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) expect_frame(mk(23'(1000 + k), 23'(1000 + k)));
            drive(2'b11, 23'(1000 + k));
        end
        check("bp_drops", 64'(drops), 64'd2);
        check("bp_valid", 64'(o_valid), 64'd1);
        check("bp_head", 64'(o_data), 64'(mk(23'd1000, 23'd1000)));
        check("bp_hold", 64'(hold), 64'(mk(23'd1017, 23'd1017)));
        o_ready = 1'b1;
        drain();

        // Full FIFO with push and pop on the same edge
        o_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            expect_frame(mk(23'(2000 + k), 23'(2000 + k)));
            drive(2'b11, 23'(2000 + k));
        end
        check("full_drops", 64'(drops), 64'd2);
        o_ready = 1'b1;
        expect_frame(mk(23'd3000, 23'd3000));
        drive(2'b11, 23'd3000);
        check("full_pop_push_drops", 64'(drops), 64'd2);
        drain();

        // Asynchronous reset with frames queued and a pending bit set
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) drive(2'b11, 23'(4000 + k));
        drive(2'b01, 23'd55);
        check("pre_rst_valid", 64'(o_valid), 64'd1);
        check("pre_rst_hold", 64'(hold), 64'(mk(23'd55, 23'd4004)));
        q.delete();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(o_valid), 64'd0);
        check("mid_rst_drops", 64'(drops), 64'd0);
        check("mid_rst_overrun", 64'(overrun), 64'd0);
        check("mid_rst_hold", 64'(hold), 64'd0);
        check("mid_rst_data", 64'(o_data), 64'd0);
        #1 rst = 1'b1;
        o_ready = 1'b1;
        drive(2'b10, 23'd6);
        check("post_rst_pend_clear", 64'(o_valid), 64'd0);
        check("post_rst_hold", 64'(hold), 64'(mk(23'd0, 23'd6)));
        expect_frame(mk(23'd8, 23'd6));
        drive(2'b01, 23'd8);
        check("post_rst_valid", 64'(o_valid), 64'd1);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
